// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the I/D-cache to main-memory arbiter.
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  // Grant ids
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Default geometry
  localparam int unsigned DefWordsPerBlock = 8;
  localparam int unsigned DefMemLatency    = 4;

  // Byte address of the first word of the block holding addr.
  function automatic logic [15:0] block_base(input logic [15:0] addr,
                                             input int unsigned words);
    return addr & ~16'(2 * words - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter, grouped as one bundle.
// slave: the arbiter's view. master: the caches plus memory around it.
interface mem_arbiter_if;
  logic        i_miss;
  logic [15:0] i_addr;
  logic        i_service;
  logic        i_data_valid;
  logic [15:0] i_data;

  logic        d_miss;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_service;
  logic        d_data_valid;
  logic [15:0] d_data;

  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  modport slave (
    input  i_miss, i_addr, d_miss, d_write, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_service, i_data_valid, i_data, d_service, d_data_valid, d_data,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_miss, i_addr, d_miss, d_write, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_service, i_data_valid, i_data, d_service, d_data_valid, d_data,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant picker between the I- and D-cache requests.
// ARB_ROUND_ROBIN_EN: when both request, grant the port not granted last.
// Otherwise D always wins over I.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  assign valid_o = i_req_i | d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  // Alternate on contention, otherwise grant whoever asks.
  always_comb begin
    if (i_req_i && d_req_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = d_req_i ? PORT_D : PORT_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Fixed priority: D over I.
  always_comb begin
    grant_o = d_req_i ? PORT_D : PORT_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache block fills and D-cache fills/write-throughs onto one
// pipelined main memory. Contention policy lives in arb_pick
// (ARB_ROUND_ROBIN_EN selects round robin, default is D-over-I priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = DefWordsPerBlock,
  // Memory read latency; returns are counted, so no logic depends on it.
  parameter int unsigned MEM_LATENCY     = DefMemLatency
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus_io
);

  localparam int unsigned     CntW   = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WORDS_PER_BLOCK);

  logic [1:0]      state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [15:0]     addr_q, addr_d;   // block base for fills, word address for writes
  logic [15:0]     wdata_q, wdata_d;
  logic [CntW-1:0] issue_q, issue_d;
  logic [CntW-1:0] ret_q, ret_d;
  logic            pick_id, pick_valid;
  logic [15:0]     addr_sel;
  logic            is_write;

  arb_pick u_arb_pick (
    .i_req_i      (bus_io.i_miss),
    .d_req_i      (bus_io.d_miss),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_id),
    .valid_o      (pick_valid)
  );

  // Next-state: grant in IDLE, count issues and returns in FILL.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    issue_d      = issue_q;
    ret_d        = ret_q;
    addr_sel     = (pick_id == PORT_D) ? bus_io.d_addr : bus_io.i_addr;
    is_write     = (pick_id == PORT_D) && bus_io.d_write;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_id;
          last_grant_d = pick_id;
          addr_d       = is_write ? addr_sel : block_base(addr_sel, WORDS_PER_BLOCK);
          wdata_d      = bus_io.d_wdata;
          issue_d      = '0;
          ret_d        = '0;
          state_d      = is_write ? WRITE : FILL;
        end
      end
      FILL: begin
        if (issue_q != CntMax) begin
          issue_d = issue_q + 1'b1;
        end
        if (bus_io.mem_rvalid && (ret_q != CntMax)) begin
          ret_d = ret_q + 1'b1;
          if (ret_q == CntMax - 1'b1) begin
            state_d = GAP;
          end
        end
      end
      WRITE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; fill data passes straight through to the grantee.
  always_comb begin
    bus_io.i_service    = 1'b0;
    bus_io.i_data_valid = 1'b0;
    bus_io.i_data       = '0;
    bus_io.d_service    = 1'b0;
    bus_io.d_data_valid = 1'b0;
    bus_io.d_data       = '0;
    bus_io.mem_enable   = 1'b0;
    bus_io.mem_wr       = 1'b0;
    bus_io.mem_addr     = '0;
    bus_io.mem_wdata    = '0;
    unique case (state_q)
      FILL: begin
        if (issue_q != CntMax) begin
          bus_io.mem_enable = 1'b1;
          bus_io.mem_addr   = addr_q + 16'({issue_q, 1'b0});
        end
        if (grant_q == PORT_D) begin
          bus_io.d_service    = 1'b1;
          bus_io.d_data_valid = bus_io.mem_rvalid;
          bus_io.d_data       = bus_io.mem_rdata;
        end else begin
          bus_io.i_service    = 1'b1;
          bus_io.i_data_valid = bus_io.mem_rvalid;
          bus_io.i_data       = bus_io.mem_rdata;
        end
      end
      WRITE: begin
        bus_io.mem_enable = 1'b1;
        bus_io.mem_wr     = 1'b1;
        bus_io.mem_addr   = addr_q;
        bus_io.mem_wdata  = wdata_q;
        bus_io.d_service  = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= PORT_I;
      last_grant_q <= PORT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      issue_q      <= '0;
      ret_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      issue_q      <= issue_d;
      ret_q        <= ret_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory requests
// and fill words into queues, monitors pop and compare on the falling edge.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .WORDS_PER_BLOCK (W),
    .MEM_LATENCY     (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } dat_exp_t;

  mem_exp_t mem_q[$];
  dat_exp_t dat_q[$];

  // Memory model: fixed-latency read pipe, read data derived from address.
  function automatic logic [15:0] rd_model(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];
  logic           stray_rv = 1'b0;
  logic [15:0]    stray_d  = 16'h0;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], bus.mem_enable & ~bus.mem_wr};
    pa[0] <= bus.mem_addr;
    for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
  end

  assign bus.mem_rvalid = pv[LAT-1] | stray_rv;
  assign bus.mem_rdata  = stray_rv ? stray_d : rd_model(pa[LAT-1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: memory requests and fill words against the queues.
  always @(negedge clk) begin
    mem_exp_t me;
    dat_exp_t de;
    if (bus.mem_enable === 1'b1) begin
      if (mem_q.size() == 0) begin
        check("mem_unexpected_req", {16'h0, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        me = mem_q.pop_front();
        check("mem_wr", bus.mem_wr, me.wr);
        check("mem_addr", bus.mem_addr, me.addr);
        if (me.wr) check("mem_wdata", bus.mem_wdata, me.wdata);
      end
    end
    if (bus.i_data_valid === 1'b1 && bus.d_data_valid === 1'b1) begin
      check("both_data_valid", 1, 0);
    end else if (bus.i_data_valid === 1'b1 || bus.d_data_valid === 1'b1) begin
      if (dat_q.size() == 0) begin
        check("data_unexpected", {15'h0, bus.d_data_valid, bus.i_data_valid}, 0);
      end else begin
        de = dat_q.pop_front();
        check("data_port", bus.d_data_valid, de.port);
        check("data_word", bus.d_data_valid ? bus.d_data : bus.i_data, de.data);
      end
    end
  end

  task automatic push_fill(input logic port, input logic [15:0] addr,
                           input int n_mem, input int n_dat);
    logic [15:0] base;
    base = addr & ~16'(2 * W - 1);
    for (int k = 0; k < n_mem; k++) mem_q.push_back({1'b0, 16'(base + 2 * k), 16'h0});
    for (int k = 0; k < n_dat; k++) dat_q.push_back({port, rd_model(16'(base + 2 * k))});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_i_service"},    bus.i_service,    0);
    check({pfx, "_d_service"},    bus.d_service,    0);
    check({pfx, "_mem_enable"},   bus.mem_enable,   0);
    check({pfx, "_mem_wr"},       bus.mem_wr,       0);
    check({pfx, "_mem_addr"},     bus.mem_addr,     0);
    check({pfx, "_mem_wdata"},    bus.mem_wdata,    0);
    check({pfx, "_i_data_valid"}, bus.i_data_valid, 0);
    check({pfx, "_d_data_valid"}, bus.d_data_valid, 0);
    check({pfx, "_i_data"},       bus.i_data,       0);
    check({pfx, "_d_data"},       bus.d_data,       0);
  endtask

  task automatic check_drained(input string pfx);
    check({pfx, "_mem_q_left"}, mem_q.size(), 0);
    check({pfx, "_dat_q_left"}, dat_q.size(), 0);
  endtask

  logic first_d;
  logic first_exp, second_exp;

  initial begin
    bus.i_miss  = 1'b0;
    bus.i_addr  = 16'h0;
    bus.d_miss  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = 16'h0;
    bus.d_wdata = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    next_cycle();

    // Basic I fill at 0x1236: block 0x1230, service cycles 1-12, data 5-12, GAP 13
    bus.i_miss = 1'b1;
    bus.i_addr = 16'h1236;
    push_fill(PORT_I, 16'h1236, W, W);
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      if (c == 1) begin
        bus.i_miss = 1'b0;
        bus.i_addr = 16'hFFFF;
      end
      @(negedge clk);
      check("fill_i_service", bus.i_service, (c <= 12));
      check("fill_i_valid_window", bus.i_data_valid, (c >= 5 && c <= 12));
      if (c == 13) begin
        check("fill_gap_d_service", bus.d_service, 0);
        check("fill_gap_mem_enable", bus.mem_enable, 0);
      end
    end
    check_drained("fill");

    // Write-through: one cycle at unaligned 0x00A3 with 0xBEEF
    bus.d_miss  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_addr  = 16'h00A3;
    bus.d_wdata = 16'hBEEF;
    mem_q.push_back({1'b1, 16'h00A3, 16'hBEEF});
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 1) begin
        bus.d_miss  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = 16'h5555;
        bus.d_wdata = 16'h1111;
      end
      @(negedge clk);
      check("wr_d_service", bus.d_service, (c == 1));
      check("wr_mem_wr", bus.mem_wr, (c == 1));
      check("wr_mem_wdata", bus.mem_wdata, (c == 1) ? 16'hBEEF : 16'h0000);
      check("wr_d_data_valid", bus.d_data_valid, 0);
    end
    check_drained("write");

    // Simultaneous read misses; the second port stays requesting through GAP
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;  // last grant was D (the write)
`else
    first_d = 1'b1;
`endif
    bus.i_miss  = 1'b1;
    bus.i_addr  = 16'h2006;
    bus.d_miss  = 1'b1;
    bus.d_write = 1'b0;
    bus.d_addr  = 16'h3456;
    if (first_d) begin
      push_fill(PORT_D, 16'h3456, W, W);
      push_fill(PORT_I, 16'h2006, W, W);
    end else begin
      push_fill(PORT_I, 16'h2006, W, W);
      push_fill(PORT_D, 16'h3456, W, W);
    end
    for (int c = 1; c <= 28; c++) begin
      next_cycle();
      if (c == 1) begin
        if (first_d) begin
          bus.d_miss = 1'b0;
          bus.d_addr = 16'h7777;
        end else begin
          bus.i_miss = 1'b0;
          bus.i_addr = 16'h7777;
        end
      end
      if (c == 15) begin
        bus.i_miss = 1'b0;
        bus.d_miss = 1'b0;
      end
      @(negedge clk);
      first_exp  = (c <= 12);
      second_exp = (c >= 15 && c <= 26);
      check("sim_d_service", bus.d_service, first_d ? first_exp : second_exp);
      check("sim_i_service", bus.i_service, first_d ? second_exp : first_exp);
    end
    check_drained("sim");

    // Reset in the 3rd FILL cycle: three reads issued, late returns dropped
    bus.i_miss = 1'b1;
    bus.i_addr = 16'h4000;
    push_fill(PORT_I, 16'h4000, 3, 0);
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      if (c == 1) bus.i_miss = 1'b0;
      if (c == 3) rst = 1'b0;
      if (c == 4) rst = 1'b1;
      @(negedge clk);
      if (c == 4) check_quiet("rst_mid");
      if (c >= 4) begin
        check("rst_late_i_valid", bus.i_data_valid, 0);
        check("rst_late_i_service", bus.i_service, 0);
      end
    end
    check_drained("rst");

    // Stray memory return while IDLE
    next_cycle();
    stray_rv = 1'b1;
    stray_d  = 16'hDEAD;
    @(negedge clk);
    check("stray_i_valid", bus.i_data_valid, 0);
    check("stray_d_valid", bus.d_data_valid, 0);
    check("stray_i_data", bus.i_data, 0);
    check("stray_d_data", bus.d_data, 0);
    next_cycle();
    stray_rv = 1'b0;
    repeat (2) next_cycle();
    check_drained("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
